// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: WIDTH-bit adder that reuses one 16-bit slice adder over WIDTH/16 cycles
module adder_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {16'd0, cin_i};
endmodule

module adder_seq_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             cin_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] SUM_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o
);
    localparam int NSLICE = WIDTH / 16;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (WIDTH % 16 != 0 || WIDTH < 16) begin : g_width_chk
        $error("adder_seq_ctrl: WIDTH must be a multiple of 16 and >= 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [15:0]      sl_a, sl_b, sl_sum;
    logic             sl_cout;
    logic             last;

    adder_16bit u_add (
        .a_i    (sl_a),
        .b_i    (sl_b),
        .cin_i  (carry_q),
        .sum_o  (sl_sum),
        .cout_o (sl_cout)
    );

    assign last          = idx_q == IW'(NSLICE - 1);
    assign start_ready_o = state_q == IDLE;
    assign res_valid_o   = state_q == DONE;
    assign busy_o        = state_q != IDLE;
    assign SUM_o         = sum_q;
    assign cout_o        = cout_q;
    assign ovf_o         = ovf_q;

    // select the operand slice addressed by the current index
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IW'(i)) begin
                sl_a = a_q[16*i +: 16];
                sl_b = b_q[16*i +: 16];
            end
        end
    end

    // sequencing FSM and per-slice datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (start_valid_i) begin
                    a_d     = A_i;
                    b_d     = B_i;
                    carry_d = cin_i;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (idx_q == IW'(i)) sum_d[16*i +: 16] = sl_sum;
                end
                carry_d = sl_cout;
                idx_d   = last ? '0 : idx_q + IW'(1);
                if (last) begin
                    state_d = DONE;
                    cout_d  = sl_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_sum[15] != a_q[WIDTH-1]);
                end
            end
            DONE: state_d = res_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: scoreboard bench for the sequenced wide adder
module tb_adder_seq_ctrl;
    localparam int W = 64;
    localparam int NS = W / 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_valid_i = 1'b0;
    logic         cin_i = 1'b0;
    logic         res_ready_i = 1'b0;
    logic [W-1:0] A_i = '0;
    logic [W-1:0] B_i = '0;
    logic         start_ready_o, res_valid_o, cout_o, ovf_o, busy_o;
    logic [W-1:0] SUM_o;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    adder_seq_ctrl #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_valid_i (start_valid_i),
        .start_ready_o (start_ready_o),
        .A_i           (A_i),
        .B_i           (B_i),
        .cin_i         (cin_i),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .SUM_o         (SUM_o),
        .cout_o        (cout_o),
        .ovf_o         (ovf_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // reference: plain unsigned sum plus signed range test
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0]          u;
        logic signed [W+1:0] s;
        exp_t                e;
        u = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        s = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}) + $signed({{(W+1){1'b0}}, c});
        e.sum  = u[W-1:0];
        e.cout = u[W];
        e.ovf  = (s > $signed({3'b000, {(W-1){1'b1}}})) || (s < $signed({3'b111, {(W-1){1'b0}}}));
        return e;
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            default: return rnd64();
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk1({tag, "_start_ready"}, start_ready_o, 1'b1);
        chk1({tag, "_res_valid"}, res_valid_o, 1'b0);
        chk1({tag, "_busy"}, busy_o, 1'b0);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_sum"}, SUM_o, '0);
        chk1({tag, "_cout"}, cout_o, 1'b0);
        chk1({tag, "_ovf"}, ovf_o, 1'b0);
        idle_chk(tag);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, output bit ok);
        int k = 0;
        start_valid_i = 1'b1;
        A_i = a;
        B_i = b;
        cin_i = c;
        @(negedge clk);
        while (!start_ready_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        ok = start_ready_o;
        chk1("accept_ready", start_ready_o, 1'b1);
        if (!ok) begin
            step();
            start_valid_i = 1'b0;
            return;
        end
        step();
        acc_cyc = cyc;
        q.push_back(model(a, b, c));
        start_valid_i = 1'b0;
    endtask

    task automatic complete(input exp_t e, input int hold);
        int k = 0;
        int h = 0;
        bit got = 0;
        while (!got && k < 20) begin
            A_i = rnd64();
            B_i = rnd64();
            cin_i = 1'($urandom_range(0, 1));
            start_valid_i = 1'($urandom_range(0, 1));
            res_ready_i = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (res_valid_o) got = 1;
            else begin
                chk1("run_start_ready", start_ready_o, 1'b0);
                chk1("run_busy", busy_o, 1'b1);
                step();
            end
            k++;
        end
        if (!got) begin
            chk1("result_timeout", res_valid_o, 1'b1);
            return;
        end
        while (!res_ready_i) begin
            chk("hold_sum", SUM_o, e.sum);
            chk1("hold_cout", cout_o, e.cout);
            chk1("hold_ovf", ovf_o, e.ovf);
            chk1("hold_start_ready", start_ready_o, 1'b0);
            chk1("hold_valid", res_valid_o, 1'b1);
            step();
            A_i = rnd64();
            B_i = rnd64();
            start_valid_i = 1'b1;
            h++;
            res_ready_i = (h >= hold);
            @(negedge clk);
        end
        step();
        res_ready_i = 1'b0;
        start_valid_i = 1'b0;
        @(negedge clk);
        idle_chk("post_result");
        step();
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int hold);
        bit ok;
        issue(a, b, c, ok);
        if (ok) complete(model(a, b, c), hold);
    endtask

    // monitor: scoreboard compare on every result handshake, latency on every rise
    initial begin : mon
        exp_t e;
        logic pv;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_ni && res_valid_o && !pv) chk("latency", W'(cyc - acc_cyc), W'(NS));
            if (rst_ni && res_valid_o && res_ready_i) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got sum %h required no result", SUM_o);
                end else begin
                    e = q.pop_front();
                    chk("sum", SUM_o, e.sum);
                    chk1("cout", cout_o, e.cout);
                    chk1("ovf", ovf_o, e.ovf);
                end
            end
            pv = res_valid_o;
        end
    end

    initial begin : drv
        bit ok;
        for (int i = 0; i < 2; i++) begin
            A_i = rnd64();
            B_i = rnd64();
            cin_i = 1'($urandom_range(0, 1));
            start_valid_i = 1'($urandom_range(0, 1));
            res_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        @(negedge clk);
        reset_chk("reset");
        step();
        rst_ni = 1'b1;
        start_valid_i = 1'b0;
        res_ready_i = 1'b0;
        step();
        run(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0);
        run(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1);
        run(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 2);
        run(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0);
        run(rnd64(), rnd64(), 1'b1, 6);
        issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, ok);
        if (ok) begin
            step();
            step();
            rst_ni = 1'b0;
            step();
            rst_ni = 1'b1;
            @(negedge clk);
            reset_chk("mid_reset");
            void'(q.pop_back());
            for (int i = 0; i < 6; i++) begin
                step();
                @(negedge clk);
                chk1("mid_reset_no_valid", res_valid_o, 1'b0);
            end
            step();
        end
        run(64'h1, 64'h2, 1'b0, 0);
        for (int i = 0; i < 40; i++) run(pick(), pick(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        @(negedge clk);
        chk("queue_drained", W'(q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: bench did not finish, required finish before time limit");
        $fatal(1);
    end
endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Sequenced wide adder. Adds WIDTH-bit operands by time-multiplexing one adder_16bit instance over WIDTH/16 cycles, low slice first.
- A registered carry links each slice to the next.
- valid/ready handshakes on both the request side and the result side.
- Area-optimised alternative to a full-width ripple adder in the adder comparison suite.

Parameters:
- WIDTH, 64, operand/result width. Must be a multiple of 16 and >= 16; elaboration error otherwise.
- NSLICE, WIDTH/16, derived number of 16-bit slices. Localparam, not overridable.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  synchronous active-low reset.
- start_valid_i  input  1  request valid.
- start_ready_o  output  1  request ready; high only in IDLE.
- A_i  input  WIDTH  operand A, sampled on request handshake.
- B_i  input  WIDTH  operand B, sampled on request handshake.
- cin_i  input  1  carry-in, sampled on request handshake.
- res_valid_o  output  1  result valid.
- res_ready_i  input  1  result accepted.
- SUM_o  output  WIDTH  registered sum.
- cout_o  output  1  registered carry-out of bit WIDTH-1.
- ovf_o  output  1  registered two's-complement signed overflow.
- busy_o  output  1  high in RUN and DONE.

Behaviour:
- Reset (rst_ni=0 at clock edge):
  - state=IDLE, slice index=0, carry reg=0, operand regs=0.
  - SUM_o=0, cout_o=0, ovf_o=0, res_valid_o=0, busy_o=0, start_ready_o=1 (IDLE).
  - Reset mid-RUN or mid-DONE discards the operation; no result is produced.
- FSM states: IDLE, RUN, DONE. All outputs are decoded from registers; there is no combinational input-to-output path.
- IDLE:
  - start_ready_o=1.
  - On start_valid_i=1: capture A_i, B_i and cin_i (cin_i into the carry reg), set index to 0, go to RUN.
- RUN, each cycle:
  - Adder inputs: A_reg[16*idx+:16], B_reg[16*idx+:16], carry reg.
  - At the edge: sum slice is written to result bits [16*idx+:16]; carry reg <= adder cout; idx <= idx+1.
  - When idx==NSLICE-1: go to DONE; cout_o <= adder cout; ovf_o <= (A_reg[W-1]==B_reg[W-1]) && (final sum[W-1]!=A_reg[W-1]).
- Latency: request handshake at edge t; res_valid_o=1 after edge t+NSLICE (4 cycles for WIDTH=64). NSLICE=1 gives a single RUN cycle.
- DONE:
  - res_valid_o=1; SUM_o, cout_o and ovf_o stay stable while res_ready_i=0.
  - On res_ready_i=1: go to IDLE, res_valid_o=0 next cycle.
  - SUM_o, cout_o and ovf_o keep their last values until the next DONE.
- SUM_o during RUN: holds partial result bits and is don't-care while res_valid_o=0.
- Throughput: one operation per NSLICE+2 cycles at best. No request is accepted in DONE, even when a result handshake happens in the same cycle.
- Inputs ignored outside their handshake:
  - A_i, B_i and cin_i changes after capture are ignored.
  - start_valid_i is ignored in RUN and DONE.
  - res_ready_i is ignored outside DONE.
- Arithmetic: SUM_o = (A+B+cin) mod 2^WIDTH; cout_o = bit WIDTH of the full sum.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with random inputs toggling -> SUM_o=0, cout_o=0, ovf_o=0, res_valid_o=0, busy_o=0, start_ready_o=1.
- Full-width carry (WIDTH=64): A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> SUM_o=0, cout_o=1, ovf_o=0; res_valid_o rises exactly 4 cycles after the accept edge.
- Slice boundary carry: A=0x0000_0000_0000_FFFF, B=0x1, cin=0 -> SUM_o=0x0000_0000_0001_0000, cout_o=0.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> SUM_o=0x8000_0000_0000_0000, cout_o=0, ovf_o=1. Then A=B=0x8000_0000_0000_0000 -> SUM_o=0, cout_o=1, ovf_o=1.
- Backpressure and input isolation:
  - Stimulus: change A_i/B_i during RUN, pulse start_valid_i in RUN, hold res_ready_i=0 for 6 cycles in DONE.
  - Required: result unaffected, outputs stable, start_ready_o=0 throughout; IDLE reached one cycle after res_ready_i=1.
- Reset mid-operation: assert rst_ni=0 in RUN with idx=2 -> next cycle all outputs at reset values and no res_valid_o pulse. A new request 0x1+0x2 then yields SUM_o=0x3.
